rev_arbiter: RTL and testbench

Round-robin scheduler that shares a single bit-reversing output register among R requesters. Each cycle it selects at most one valid requester, captures its N-bit word bit-reversed (or straight, per `rev_en`) into the shared register, and presents it downstream with a valid/ready handshake and the winner's ID. It sits in front of a consumer that expects reordered words and replaces per-requester private reorder registers.

---
 rtl/rev_arbiter.sv | 139 +++++++++++++
 tb/tb_rev_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rev_arbiter.sv
// ============================================================================
// Module      : rev_arbiter
// Description : Round-robin arbiter feeding one shared, optionally
//               bit-reversing output register with a valid/ready handshake.
//               Optional out_parity port: define REV_ARBITER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rev_arbiter #(
    parameter  int N  = 8,
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rev_en,
    input  logic [R-1:0]    req_valid,
    input  logic [R*N-1:0]  req_data,
    output logic [R-1:0]    req_ready,
    output logic            out_valid,
    output logic [N-1:0]    out_data,
    output logic [IW-1:0]   out_id,
`ifdef REV_ARBITER_PARITY_EN
    output logic            out_parity,
`endif
    input  logic            out_ready
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] out_id_q, out_id_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;

    logic [IW-1:0] w_grant;
    logic          w_found;
    logic          w_can_load;
    logic          w_accept;
    logic [N-1:0]  w_word;
    logic [N-1:0]  w_rev;

    assign w_can_load = !out_valid_q || out_ready;

    // Two passes: requesters at or above ptr first, then the wrapped low
    // indices; the second pass only runs when nothing at or above ptr is valid.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_word  = '0;
        for (int k = 0; k < R; k++) begin
            if (!w_found && req_valid[k] && (IW'(k) >= ptr_q)) begin
                w_found = 1'b1;
                w_grant = IW'(k);
                w_word  = req_data[k*N +: N];
            end
        end
        for (int k = 0; k < R; k++) begin
            if (!w_found && req_valid[k]) begin
                w_found = 1'b1;
                w_grant = IW'(k);
                w_word  = req_data[k*N +: N];
            end
        end
    end

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < N; i++) begin
            w_rev[i] = w_word[N-1-i];
        end
    end

    assign w_accept = !reset && w_can_load && w_found;

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < R; k++) begin
            req_ready[k] = w_accept && (w_grant == IW'(k));
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = rev_en ? w_rev : w_word;
            out_id_d    = w_grant;
            ptr_d       = (w_grant == IW'(R - 1)) ? '0 : w_grant + IW'(1);
        end else if (w_can_load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef REV_ARBITER_PARITY_EN
    logic out_parity_q, out_parity_d;

    // Parity follows the stored word, so it is updated only on accept.
    always_comb begin
        out_parity_d = out_parity_q;
        if (w_accept) begin
            out_parity_d = ^out_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= out_parity_d;
        end
    end

    assign out_parity = out_parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rev_arbiter.sv
// ============================================================================
// Module      : tb_rev_arbiter
// Description : Self-checking bench for rev_arbiter (R=4 main, R=3 wrap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rev_arbiter;
    localparam int N = 8;
    localparam int R = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           rev_en;
    logic           out_ready;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_data;
    logic           out_valid;
    logic [N-1:0]   out_data;
    logic [1:0]     out_id;

    logic [2:0]     req_valid3;
    logic [2:0]     req_ready3;
    logic [3*N-1:0] req_data3;
    logic           out_valid3;
    logic [N-1:0]   out_data3;
    logic [1:0]     out_id3;
`ifdef REV_ARBITER_PARITY_EN
    logic           out_parity;
    logic           out_parity3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rev_arbiter #(.N(N), .R(R)) dut (
        .clock     (clock),
        .reset     (reset),
        .rev_en    (rev_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
`ifdef REV_ARBITER_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    rev_arbiter #(.N(N), .R(3)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .rev_en    (rev_en),
        .req_valid (req_valid3),
        .req_data  (req_data3),
        .req_ready (req_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_id    (out_id3),
`ifdef REV_ARBITER_PARITY_EN
        .out_parity(out_parity3),
`endif
        .out_ready (out_ready)
    );

    // Reference model of the R=4 instance, written from the scheduling rules.
    int           m_ptr;
    int           m_grant;
    int           m_id;
    bit           m_valid;
    bit           m_par;
    logic [N-1:0] m_data;
    logic [R-1:0] m_ready;

    logic [2:0]   exp_r3;
    bit           chk3;

    function automatic void model_arb();
        m_grant = -1;
        for (int j = 0; j < R; j++) begin
            int k;
            k = (m_ptr + j) % R;
            if (m_grant < 0 && req_valid[k]) m_grant = k;
        end
        m_ready = '0;
        if (!reset && (!m_valid || out_ready) && m_grant >= 0) m_ready[m_grant] = 1'b1;
    endfunction

    function automatic void model_clk();
        logic [N-1:0] w;
        if (reset) begin
            m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0; m_par = 0;
        end else if (m_ready != '0) begin
            w       = req_data[m_grant*N +: N];
            m_data  = rev_en ? {<<{w}} : w;
            m_par   = ^m_data;
            m_id    = m_grant;
            m_valid = 1;
            m_ptr   = (m_grant + 1) % R;
        end else if (!m_valid || out_ready) begin
            m_valid = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check at the falling edge, advance the model on the rising edge.
    task automatic cyc();
        @(negedge clock);
        model_arb();
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_id", 32'(out_id), 32'(m_id));
`ifdef REV_ARBITER_PARITY_EN
        chk("out_parity", 32'(out_parity), 32'(m_par));
`endif
        if (chk3) chk("req_ready3", 32'(req_ready3), 32'(exp_r3));
        @(posedge clock);
        model_clk();
        #1;
    endtask

    logic [N-1:0] hold_data;
    logic [1:0]   hold_id;

    initial begin
        reset = 1'b1; rev_en = 1'b0; out_ready = 1'b1;
        req_valid = '1; req_valid3 = '0; req_data3 = '0; chk3 = 0; exp_r3 = '0;
        m_ready = '0;
        for (int k = 0; k < R; k++) req_data[k*N +: N] = N'($urandom);
        @(posedge clock);
        model_clk();
        #1;

        // Reset held with every requester valid
        repeat (2) cyc();
        chk("rst_ready", 32'(req_ready), 32'h0);
        reset = 1'b0;
        cyc();
        chk("first_id", 32'(out_id), 32'd0);
        chk("first_valid", 32'(out_valid), 32'd1);

        // Bit reversal on requester 2
        req_valid = 4'b0100;
        req_data[2*N +: N] = 8'b0000_0011;
        rev_en = 1'b1;
        cyc();
        chk("rev_data", 32'(out_data), 32'hC0);
        chk("rev_id", 32'(out_id), 32'd2);
        rev_en = 1'b0;
        cyc();
        chk("straight_data", 32'(out_data), 32'h03);
        chk("straight_id", 32'(out_id), 32'd2);

`ifdef REV_ARBITER_PARITY_EN
        req_data[2*N +: N] = 8'hA7;
        cyc();
        chk("parity_a7", 32'(out_parity), 32'd1);
        req_data[2*N +: N] = 8'h03;
        cyc();
        chk("parity_03", 32'(out_parity), 32'd0);
`endif

        // Fairness from a fresh reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("fair_id", 32'(out_id), 32'(i % 4));
            chk("fair_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure for 5 cycles
        out_ready = 1'b0;
        hold_data = out_data;
        hold_id   = out_id;
        repeat (5) begin
            cyc();
            chk("bp_data", 32'(out_data), 32'(hold_data));
            chk("bp_id", 32'(out_id), 32'(hold_id));
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_release_id", 32'(out_id), 32'd2);

        // Wrap with R=3: reach ptr=2, then requesters 0 and 2 valid
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_valid = '0;
        chk3 = 1;
        req_valid3 = 3'b111;
        req_data3 = 24'h5A_3C_81;
        exp_r3 = 3'b001; cyc();
        exp_r3 = 3'b010; cyc();
        req_valid3 = 3'b101;
        exp_r3 = 3'b100; cyc();
        chk("wrap_id2", 32'(out_id3), 32'd2);
        exp_r3 = 3'b001; cyc();
        chk("wrap_id0", 32'(out_id3), 32'd0);
        chk("wrap_data0", 32'(out_data3), 32'h81);
        chk3 = 0;
        req_valid3 = '0;

        // Randomized traffic, requesters hold words until accepted
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 49) == 0);
            rev_en    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < R; k++) begin
                if (!req_valid[k]) begin
                    req_valid[k] = 1'($urandom);
                    req_data[k*N +: N] = N'($urandom);
                end
            end
            cyc();
            for (int k = 0; k < R; k++) begin
                if (m_ready[k]) req_valid[k] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
